// File: rtl/uart_rx_if.sv
// Byte stream from the UART receiver to its consumer.
// data is meaningful only while valid; ready accepts it.
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled bit recovery.
// Delivers bytes on a valid/ready stream; flags framing and overrun.
module uart_rx #(
    parameter int CLOCK_FREQ = 12_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      rx,
    uart_rx_if.master bus,
    output logic      frame_err,
    output logic      overrun
);
    localparam int TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [3:0]  S_MID     = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]  S_LAST    = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t      state, state_n;
    logic [1:0]  sync;
    logic        rx_s;
    logic [15:0] tcnt;
    logic        tick;
    logic [3:0]  scnt, scnt_n;
    logic [2:0]  bcnt, bcnt_n;
    logic [7:0]  shreg, shreg_n;
    logic        deliver;
    logic        ferr;

    assign rx_s = sync[1];
    assign tick = (tcnt == TICK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= 2'b11;
            tcnt <= '0;
        end else begin
            sync <= {sync[0], rx};
            tcnt <= tick ? 16'd0 : tcnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            scnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            scnt  <= scnt_n;
            bcnt  <= bcnt_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        deliver = 1'b0;
        ferr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick && !rx_s) begin
                    scnt_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    scnt_n = scnt + 4'd1;
                    if (scnt == S_MID) begin
                        if (!rx_s) begin
                            scnt_n  = '0;
                            bcnt_n  = '0;
                            state_n = DATA;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    scnt_n = scnt + 4'd1;
                    if (scnt == S_LAST) begin
                        shreg_n = {rx_s, shreg[7:1]};
                        bcnt_n  = bcnt + 3'd1;
                        if (bcnt == 3'd7) begin
                            scnt_n  = '0;
                            state_n = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    scnt_n = scnt + 4'd1;
                    if (scnt == S_LAST) begin
                        if (rx_s) begin
                            deliver = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr    = 1'b1;
                            state_n = WAIT_HIGH;
                        end
                    end
                end
            end
            WAIT_HIGH: begin
                // Break condition: hold off until the line returns high.
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.data  <= '0;
            bus.valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= deliver && bus.valid && !bus.ready;
            if (deliver && (!bus.valid || bus.ready)) begin
                bus.data  <= shreg;
                bus.valid <= 1'b1;
            end else if (bus.valid && bus.ready) begin
                bus.valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: fast instance at 16 clocks/bit,
// plus a default-parameter instance fed at 1248 clocks/bit.
module tb_uart_rx;
    logic clk;
    logic reset;
    logic rx;
    logic rx2;
    logic frame_err, overrun;
    logic frame_err2, overrun2;

    uart_rx_if bus();
    uart_rx_if bus2();

    uart_rx #(
        .CLOCK_FREQ(1_600_000),
        .BAUD_RATE (100_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .bus      (bus),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    uart_rx u_def (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx2),
        .bus      (bus2),
        .frame_err(frame_err2),
        .overrun  (overrun2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int vcyc = 0, fcnt = 0, ocnt = 0;
    logic [7:0] vdata = 8'h00;
    int vcyc2 = 0, ecnt2 = 0;
    logic [7:0] vdata2 = 8'h00;

    always @(negedge clk) begin
        if (bus.valid) begin
            vcyc  = vcyc + 1;
            vdata = bus.data;
        end
        if (frame_err) fcnt = fcnt + 1;
        if (overrun) ocnt = ocnt + 1;
        if (bus2.valid) begin
            vcyc2  = vcyc2 + 1;
            vdata2 = bus2.data;
        end
        if (frame_err2 || overrun2) ecnt2 = ecnt2 + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx2 = v;
        else rx = v;
    endtask

    task automatic send(input logic [7:0] b, input logic stop,
                        input int bc, input bit sel);
        @(posedge clk);
        #1 set_line(sel, 1'b0);
        repeat (bc - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 set_line(sel, b[i]);
            repeat (bc - 1) @(posedge clk);
        end
        @(posedge clk);
        #1 set_line(sel, stop);
        repeat (bc - 1) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    int v0, f0, o0, v20, e20;

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        rx2 = 1'b1;
        bus.ready = 1'b0;
        bus2.ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", bus.data, 8'h00);
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        reset = 1'b0;
        idle(10);

        // Single frame with consumer ready
        bus.ready = 1'b1;
        v0 = vcyc; f0 = fcnt; o0 = ocnt;
        send(8'hA5, 1'b1, 16, 1'b0);
        idle(20);
        chk("a5_vcyc", vcyc - v0, 1);
        chk("a5_data", vdata, 8'hA5);
        chk("a5_ferr", fcnt - f0, 0);
        chk("a5_ovr", ocnt - o0, 0);

        // Short glitch on idle line
        v0 = vcyc; f0 = fcnt;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        idle(40);
        chk("gl_vcyc", vcyc - v0, 0);
        chk("gl_ferr", fcnt - f0, 0);
        send(8'h3C, 1'b1, 16, 1'b0);
        idle(20);
        chk("gl_3c_vcyc", vcyc - v0, 1);
        chk("gl_3c_data", vdata, 8'h3C);

        // Stop bit low followed by a long break
        v0 = vcyc; f0 = fcnt;
        send(8'h3C, 1'b0, 16, 1'b0);
        repeat (640) @(posedge clk);
        #1 rx = 1'b1;
        idle(40);
        chk("brk_ferr", fcnt - f0, 1);
        chk("brk_vcyc", vcyc - v0, 0);
        send(8'h55, 1'b1, 16, 1'b0);
        idle(20);
        chk("brk_55_data", vdata, 8'h55);
        chk("brk_55_vcyc", vcyc - v0, 1);

        // Overrun with consumer stalled
        bus.ready = 1'b0;
        f0 = fcnt; o0 = ocnt;
        send(8'h11, 1'b1, 16, 1'b0);
        send(8'h22, 1'b1, 16, 1'b0);
        idle(20);
        chk("ovr_valid", bus.valid, 1'b1);
        chk("ovr_data", bus.data, 8'h11);
        chk("ovr_cnt", ocnt - o0, 1);
        chk("ovr_ferr", fcnt - f0, 0);
        @(posedge clk);
        #1 bus.ready = 1'b1;
        @(posedge clk);
        #1 bus.ready = 1'b0;
        chk("acc_valid", bus.valid, 1'b0);
        chk("acc_data", bus.data, 8'h11);

        // Accept and deliver on the same cycle
        idle(10);
        send(8'h11, 1'b1, 16, 1'b0);
        idle(10);
        chk("pend_data", bus.data, 8'h11);
        o0 = ocnt;
        fork
            send(8'h22, 1'b1, 16, 1'b0);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 bus.ready = 1'b1;
                @(posedge clk);
                #1 bus.ready = 1'b0;
            end
        join
        idle(10);
        chk("swap_data", bus.data, 8'h22);
        chk("swap_valid", bus.valid, 1'b1);
        chk("swap_ovr", ocnt - o0, 0);

        // Reset in the middle of data bit 4
        fork
            send(8'hF3, 1'b1, 16, 1'b0);
            begin
                @(posedge clk);
                repeat (84) @(posedge clk);
                #1 reset = 1'b1;
                repeat (3) @(posedge clk);
                #1 reset = 1'b0;
            end
        join
        v0 = vcyc; f0 = fcnt; o0 = ocnt;
        idle(200);
        chk("mrst_data", bus.data, 8'h00);
        chk("mrst_valid", bus.valid, 1'b0);
        chk("mrst_vcyc", vcyc - v0, 0);
        chk("mrst_err", (fcnt - f0) + (ocnt - o0), 0);
        bus.ready = 1'b1;
        send(8'hF0, 1'b1, 16, 1'b0);
        idle(20);
        chk("f0_vcyc", vcyc - v0, 1);
        chk("f0_data", vdata, 8'hF0);

        // Default parameters at 1248 clocks per bit
        v20 = vcyc2; e20 = ecnt2;
        send(8'h00, 1'b1, 1248, 1'b1);
        idle(2000);
        chk("lb00_vcyc", vcyc2 - v20, 1);
        chk("lb00_data", vdata2, 8'h00);
        v20 = vcyc2;
        send(8'hFF, 1'b1, 1248, 1'b1);
        idle(2000);
        chk("lbff_vcyc", vcyc2 - v20, 1);
        chk("lbff_data", vdata2, 8'hFF);
        chk("lb_err", ecnt2 - e20, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the team's UART transmitter. It recovers 8N1 frames from the asynchronous `rx` line using a 16x-oversampled baud tick. Each received byte is presented on a valid/ready byte interface, and framing and overrun errors are flagged. It sits between the board RX pin and the byte consumer (command parser / FIFO). It is the inverse of the transmit stage and is loopback-compatible with it at identical parameters.

## Interface
- `CLOCK_FREQ`, 12_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, line rate in bit/s.
- `OVERSAMPLE`, 16, ticks per bit period.
- `TICK_DIV`, `CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE)` (integer, truncated; 78 at defaults), clocks per tick. Must be ≥1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rx`  in  1  asynchronous serial line; idle high.
- `data`  out  8  received byte; valid only while `valid`=1.
- `valid`  out  1  byte available; held until accepted.
- `ready`  in  1  consumer accepts `data` on a cycle with `valid`&&`ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a new byte completed while the previous byte was still unaccepted.

## Operation
- Synchronizer: `rx` passes through 2 flops (`rx_s`), both reset to 1. All decisions use `rx_s` only.
- Tick generator: a 16-bit counter runs freely from 0 to `TICK_DIV`-1. `tick`=1 on the cycle the counter equals `TICK_DIV`-1, then the counter wraps to 0. With `TICK_DIV`=1, `tick` is asserted every cycle.
- Sample counter: 4-bit `scnt`, advanced on `tick` only. Bit counter: 3-bit `bcnt`. Shift register: 8 bits, LSB first.
- FSM states and transitions:
  - IDLE: on `tick` with `rx_s`=0, set `scnt`=0 and go to START.
  - START: on each `tick`, increment `scnt`. At `scnt`=7 (mid start bit):
    - `rx_s`=0: set `scnt`=0, `bcnt`=0, go to DATA.
    - `rx_s`=1: false start; return to IDLE.
  - DATA: on each `tick`, increment `scnt`. At `scnt`=15, shift `rx_s` into bit 7 of the shift register (right shift) and increment `bcnt`. After the sample with `bcnt`=7, set `scnt`=0 and go to STOP.
  - STOP: at `scnt`=15:
    - `rx_s`=1: deliver the byte and go to IDLE.
    - `rx_s`=0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay while `rx_s`=0 (break condition). Go to IDLE on the first cycle `rx_s`=1.
- Deliver rules:
  - `valid`=0 before the deliver cycle: `data`←shift register, `valid`←1.
  - `valid`=1 and `ready`=1 on the same cycle: the old byte is consumed, `data`←new byte, `valid` stays 1.
  - `valid`=1 and `ready`=0: pulse `overrun`; the new byte is dropped and `data` is unchanged.
- Accept: `valid`&&`ready` with no deliver on that cycle clears `valid` on the next edge.
- `frame_err` and `overrun` never assert on the same cycle.
- Reset, including mid-frame: FSM←IDLE, counters←0, shift register←0, `data`←0, `valid`←0, `frame_err`←0, `overrun`←0, synchronizer←1. The partial byte is lost.

## Timing
- All outputs are registered.
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `overrun`=0.
- `rx` to `rx_s` delay: 2 clocks.
- Start is recognised on the first tick at which `rx_s` is low. This gives up to 1 tick of alignment error, within the ±7/16 bit sampling window.
- Sample points: 8, 24, …, 152 ticks after start recognition. Stop bit sampled at 152 ticks.
- `valid` / `frame_err` / `overrun` assert on the clock edge following the stop-sample tick.
- `data` is stable while `valid`=1 unless a same-cycle accept+deliver occurs.
- Minimum spacing between deliveries: 1 frame. Back-to-back frames with a single stop bit are received without loss.

## Test plan
Bench parameters: `CLOCK_FREQ`=1_600_000, `BAUD_RATE`=100_000 (`TICK_DIV`=1, 16 clocks/bit) unless stated.
- Frame 0xA5 with `ready`=1 → `valid` high exactly 1 cycle, `data`=0xA5, `frame_err`=`overrun`=0.
- Idle line glitched low for 4 clocks → no `valid`, no `frame_err`; FSM back in IDLE. A following 0x3C frame is received correctly.
- Frame 0x3C with stop bit 0, line held low for 40 bit times, then released → one `frame_err` pulse, no `valid`. A following 0x55 frame is received as `data`=0x55.
- `ready`=0, frames 0x11 then 0x22 back-to-back → `valid` held with `data`=0x11; one `overrun` pulse when 0x22 completes. Raising `ready` for 1 cycle clears `valid`, with `data` still 0x11.
- `ready`=1 pulsed on exactly the deliver cycle of 0x22 while 0x11 is pending → no `overrun`; `data`=0x22, `valid` stays 1.
- `reset` asserted for 3 clocks during data bit 4 of a frame → all outputs at reset values, then 0xF0 received correctly. Then loopback from the transmitter at default parameters with 0x00 and 0xFF: both received with no errors.
